// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// forward-select codes and the MEM wait counter width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned WCNT_W = 10;

endpackage

// File: rtl/pipe_fwd.sv
// EX operand forwarding compare for one source register; MEM beats WB,
// and register 0 never forwards.
module pipe_fwd
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] dstregM,
    input  logic       regwriteM,
    input  logic [4:0] dstregW,
    input  logic       regwriteW,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (regwriteW && (dstregW != 5'd0) && (dstregW == src)) begin
            sel = FWD_WB;
        end
        if (regwriteM && (dstregM != 5'd0) && (dstregM == src)) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard/sequencing controller: stalls, flushes, EX
// forwarding and MEM-wait timeout. PIPE_CTRL_PERF_EN adds stall/flush counters.
//
//   state | meaning
//   RUN   | normal issue; load-use and redirect handled here
//   MWAIT | data-memory access outstanding, whole pipe frozen
//   ERR   | MEM access timed out, pipe frozen until reset
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  dstregE,
    input  logic        memtoregE,
    input  logic [4:0]  dstregM,
    input  logic        regwriteM,
    input  logic [4:0]  dstregW,
    input  logic        regwriteW,
    input  logic        redirectM,
    input  logic        memreqM,
    input  logic        memreadyM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        busy,
    output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [WCNT_W-1:0] TIMEOUT_C = TIMEOUT[WCNT_W-1:0];

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mem_err_q, mem_err_d;
    logic                mw, lu;
    logic [1:0]          fwd_a_raw, fwd_b_raw;

    assign mw = memreqM && !memreadyM;
    assign lu = memtoregE && (dstregE != 5'd0) &&
                ((dstregE == rsD) || (dstregE == rtD));

    pipe_fwd u_fwd_a (
        .src(rsE), .dstregM(dstregM), .regwriteM(regwriteM),
        .dstregW(dstregW), .regwriteW(regwriteW), .sel(fwd_a_raw)
    );

    pipe_fwd u_fwd_b (
        .src(rtE), .dstregM(dstregM), .regwriteM(regwriteM),
        .dstregW(dstregW), .regwriteW(regwriteW), .sel(fwd_b_raw)
    );

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mw) begin
                    state_d = MWAIT;
                    wcnt_d  = {{(WCNT_W-1){1'b0}}, 1'b1};
                end
            end
            MWAIT: begin
                if (memreadyM) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == TIMEOUT_C) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ERR: begin
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Held redirect/load-use inside MWAIT falls out naturally: mw dominates
    // until memreadyM rises, then the lower-priority action shows through.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (!rst_n) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if ((state_q == ERR) || mw) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (redirectM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (lu) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    assign fwdA    = rst_n ? fwd_a_raw : FWD_RF;
    assign fwdB    = rst_n ? fwd_b_raw : FWD_RF;
    assign busy    = (state_q == MWAIT);
    assign mem_err = mem_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + (stallF ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (flushE ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default-TIMEOUT instance for hazards and
// waits, and a TIMEOUT=3 instance for the timeout/ERR path.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, rst_t_n;
    logic [4:0] rsD, rtD, rsE, rtE, dstregE, dstregM, dstregW;
    logic       memtoregE, regwriteM, regwriteW, redirectM, memreqM, memreadyM;

    logic       sF_m, sD_m, sE_m, sM_m, fD_m, fE_m, fM_m, bz_m, er_m;
    logic [1:0] fa_m, fb_m;
    logic       sF_t, sD_t, sE_t, sM_t, fD_t, fE_t, fM_t, bz_t, er_t;
    logic [1:0] fa_t, fb_t;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] scnt_m, fcnt_m, scnt_t, fcnt_t;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .dstregE(dstregE), .memtoregE(memtoregE), .dstregM(dstregM),
        .regwriteM(regwriteM), .dstregW(dstregW), .regwriteW(regwriteW),
        .redirectM(redirectM), .memreqM(memreqM), .memreadyM(memreadyM),
        .stallF(sF_m), .stallD(sD_m), .stallE(sE_m), .stallM(sM_m),
        .flushD(fD_m), .flushE(fE_m), .flushM(fM_m), .fwdA(fa_m), .fwdB(fb_m),
        .busy(bz_m), .mem_err(er_m)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(scnt_m), .flush_cnt(fcnt_m)
`endif
    );

    pipe_ctrl #(.TIMEOUT(3)) u_dut_t (
        .clk(clk), .rst_n(rst_t_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .dstregE(dstregE), .memtoregE(memtoregE), .dstregM(dstregM),
        .regwriteM(regwriteM), .dstregW(dstregW), .regwriteW(regwriteW),
        .redirectM(redirectM), .memreqM(memreqM), .memreadyM(memreadyM),
        .stallF(sF_t), .stallD(sD_t), .stallE(sE_t), .stallM(sM_t),
        .flushD(fD_t), .flushE(fE_t), .flushM(fM_t), .fwdA(fa_t), .fwdB(fb_t),
        .busy(bz_t), .mem_err(er_t)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(scnt_t), .flush_cnt(fcnt_t)
`endif
    );

    wire [12:0] obs_m = {sF_m, sD_m, sE_m, sM_m, fD_m, fE_m, fM_m, fa_m, fb_m, bz_m, er_m};
    wire [12:0] obs_t = {sF_t, sD_t, sE_t, sM_t, fD_t, fE_t, fM_t, fa_t, fb_t, bz_t, er_t};

    // {stallF,D,E,M} {flushD,E,M} fwdA fwdB busy mem_err
    function automatic logic [12:0] ev(input logic [3:0] st, input logic [2:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic bz, input logic er);
        return {st, fl, fa, fb, bz, er};
    endfunction

    task automatic chk(input string tag, input bit on_t, input logic [12:0] e);
        logic [12:0] got, want;
        exp_q.push_back(e);
        #1;
        got  = on_t ? obs_t : obs_m;
        want = exp_q.pop_front();
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic clear_in();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; dstregE = 0; dstregM = 0; dstregW = 0;
        memtoregE = 0; regwriteM = 0; regwriteW = 0; redirectM = 0;
        memreqM = 0; memreadyM = 0;
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        rst_t_n = 1'b0;

        @(negedge clk); rsE = 5; dstregM = 5; regwriteM = 1;
        chk("reset_out", 0, ev(4'b0000, 3'b111, 2'b00, 2'b00, 0, 0));

        @(negedge clk); rst_n = 1'b1; dstregW = 5; regwriteW = 1;
        chk("fwdA_mem", 0, ev(4'b0000, 3'b000, 2'b10, 2'b00, 0, 0));
        regwriteM = 0;
        chk("fwdA_wb", 0, ev(4'b0000, 3'b000, 2'b01, 2'b00, 0, 0));
        rsE = 0; dstregM = 0; regwriteM = 1; dstregW = 0;
        chk("fwdA_r0", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));
        rtE = 7; dstregW = 7; regwriteW = 1; regwriteM = 0;
        chk("fwdB_wb", 0, ev(4'b0000, 3'b000, 2'b00, 2'b01, 0, 0));
        dstregM = 7; regwriteM = 1;
        chk("fwdB_mem", 0, ev(4'b0000, 3'b000, 2'b00, 2'b10, 0, 0));
        clear_in();

        @(negedge clk); memtoregE = 1;
        chk("lu_r0", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));
        @(negedge clk); dstregE = 8; rtD = 8;
        chk("lu_hit", 0, ev(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0));
        @(negedge clk); memtoregE = 0;
        chk("lu_after", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));
        clear_in();

        @(negedge clk); memreqM = 1;
        chk("wait_c0", 0, ev(4'b1111, 3'b000, 2'b00, 2'b00, 0, 0));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("wait_c%0d", i), 0, ev(4'b1111, 3'b000, 2'b00, 2'b00, 1, 0));
        end
        @(negedge clk); memreadyM = 1;
        chk("wait_ready", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 1, 0));
        @(negedge clk); memreqM = 0; memreadyM = 0;
        chk("wait_done", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));

`ifdef PIPE_CTRL_PERF_EN
        n_tests++;
        assert (scnt_m === 32'd5) else begin
            n_fail++;
            $error("FAIL stall_cnt observed=%0d expected=5", scnt_m);
        end
        n_tests++;
        assert (fcnt_m === 32'd1) else begin
            n_fail++;
            $error("FAIL flush_cnt observed=%0d expected=1", fcnt_m);
        end
`endif

        @(negedge clk); memreqM = 1; memreadyM = 1;
        chk("wait_zero", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));
        @(negedge clk);
        chk("wait_zero_next", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));
        clear_in();

        @(negedge clk); memreqM = 1; redirectM = 1;
        chk("redir_held0", 0, ev(4'b1111, 3'b000, 2'b00, 2'b00, 0, 0));
        @(negedge clk);
        chk("redir_held1", 0, ev(4'b1111, 3'b000, 2'b00, 2'b00, 1, 0));
        @(negedge clk); memreadyM = 1;
        chk("redir_release", 0, ev(4'b0000, 3'b111, 2'b00, 2'b00, 1, 0));
        @(negedge clk); clear_in();
        chk("redir_idle", 0, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));

        @(negedge clk); redirectM = 1; memtoregE = 1; dstregE = 8; rsD = 8;
        chk("redir_over_lu", 0, ev(4'b0000, 3'b111, 2'b00, 2'b00, 0, 0));
        @(negedge clk); clear_in();

        rst_t_n = 1'b1;
        chk("t_idle", 1, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));
        @(negedge clk); memreqM = 1;
        chk("t_req", 1, ev(4'b1111, 3'b000, 2'b00, 2'b00, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("t_wait%0d", i), 1, ev(4'b1111, 3'b000, 2'b00, 2'b00, 1, 0));
        end
        @(negedge clk);
        chk("t_err", 1, ev(4'b1111, 3'b000, 2'b00, 2'b00, 0, 1));
        @(negedge clk); memreqM = 0;
        chk("t_err_hold", 1, ev(4'b1111, 3'b000, 2'b00, 2'b00, 0, 1));
        @(negedge clk); rst_t_n = 1'b0;
        chk("t_rst_low", 1, ev(4'b0000, 3'b111, 2'b00, 2'b00, 0, 1));
        @(negedge clk);
        chk("t_rst_edge", 1, ev(4'b0000, 3'b111, 2'b00, 2'b00, 0, 0));
        @(negedge clk); rst_t_n = 1'b1;
        chk("t_run", 1, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));
        @(negedge clk);
        chk("t_run_next", 1, ev(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
